// File: rtl/alu_sequencer_if.sv
// Command / ALU / response bundle for the ALU sequencer.
// The slave side is the sequencer; the master side drives commands,
// returns ALU results and reads the register file for debug.
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_srca;
  logic [1:0]  cmd_srcb;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic [15:0] alu_hi;
  logic [2:0]  alu_flags;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_hi;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    input  alu_out, alu_hi, alu_flags, rd_addr,
    output cmd_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_hi, rsp_flags, rsp_err, rd_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    output alu_out, alu_hi, alu_flags, rd_addr,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_hi, rsp_flags, rsp_err, rd_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state command sequencer around an external combinational ALU.
// IDLE accepts a command and snapshots its operands, ISSUE presents them
// to the ALU, and the ISSUE->DONE edge captures the result and writes back.
module alu_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  logic [3:0][15:0] r_regs;
  logic [2:0]       r_status;
  logic [3:0]       r_op;
  logic [1:0]       r_dst;
  logic [15:0]      r_imm;
  logic [15:0]      r_opa;
  logic [15:0]      r_opb;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_data;
  logic [15:0]      r_rsp_hi;
  logic             r_rsp_err;

  logic             w_issue;
  logic [1:0]       w_dst_hi;

  assign w_issue  = (r_state == S_ISSUE);
  // Wide results spill into the next register, wrapping R3 -> R0.
  assign w_dst_hi = r_dst + 2'd1;

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.alu_a     = w_issue ? r_opa : 16'd0;
  assign bus.alu_b     = w_issue ? r_opb : 16'd0;
  assign bus.alu_op    = w_issue ? r_op  : 4'd0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_hi    = r_rsp_hi;
  assign bus.rsp_flags = r_status;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rd_data   = r_regs[bus.rd_addr];

  // FSM, operand snapshot, result capture and register writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_regs      <= '0;
      r_status    <= 3'd0;
      r_op        <= 4'd0;
      r_dst       <= 2'd0;
      r_imm       <= 16'd0;
      r_opa       <= 16'd0;
      r_opb       <= 16'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_hi    <= 16'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (bus.cmd_valid) begin
            r_op    <= bus.cmd_op;
            r_dst   <= bus.cmd_dst;
            r_imm   <= bus.cmd_imm;
            r_opa   <= r_regs[bus.cmd_srca];
            r_opb   <= r_regs[bus.cmd_srcb];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          case (r_op)
            4'd0: begin
              r_regs[r_dst] <= r_imm;
              r_rsp_data    <= r_imm;
              r_rsp_hi      <= 16'd0;
              r_status      <= 3'd0;
            end
            4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
              r_regs[r_dst] <= bus.alu_out;
              r_rsp_data    <= bus.alu_out;
              r_rsp_hi      <= bus.alu_hi;
              r_status      <= bus.alu_flags;
            end
            4'd3, 4'd4: begin
              r_regs[r_dst]    <= bus.alu_out;
              r_regs[w_dst_hi] <= bus.alu_hi;
              r_rsp_data       <= bus.alu_out;
              r_rsp_hi         <= bus.alu_hi;
              r_status         <= bus.alu_flags;
            end
            4'd9: begin
              r_rsp_data <= bus.alu_out;
              r_rsp_hi   <= bus.alu_hi;
              r_status   <= bus.alu_flags;
            end
            default: begin
              // Illegal op: report only, status and registers untouched.
              r_rsp_err  <= 1'b1;
              r_rsp_data <= 16'd0;
              r_rsp_hi   <= 16'd0;
            end
          endcase
        end
        S_DONE: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random checks of alu_sequencer against a register-file
// model; the bench also plays the role of the combinational ALU.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_sequencer_if bus();

  alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference ALU: returns {flags, hi, out}.
  function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [2:0]  f;
    p = 32'd0;
    case (op)
      4'd1: p = {16'd0, a} + {16'd0, b};
      4'd2: p = {16'd0, a} - {16'd0, b};
      4'd3: p = {16'd0, a} * {16'd0, b};
      4'd4: p = (b == 16'd0) ? {a, 16'hffff} : {a % b, a / b};
      4'd5: p = {16'd0, a | b};
      4'd6: p = {16'd0, a & b};
      4'd7: p = {16'd0, ~a};
      4'd8: p = {16'd0, a ^ b};
      default: p = 32'd0;
    endcase
    if (op == 4'd9) f = {a < b, a == b, a > b};
    else            f = {p[15:0] == 16'd0, p[15], p[31:16] != 16'd0};
    return {f, p};
  endfunction

  assign {bus.alu_flags, bus.alu_hi, bus.alu_out} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  logic [15:0] m_regs [4];
  logic [2:0]  m_stat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), {16'd0, bus.rd_data}, {16'd0, m_regs[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'd0;
    m_stat = 3'd0;
  endtask

  // One full command: accept, ISSUE, DONE, back in IDLE.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [15:0] imm);
    logic [15:0] a, b, ed, eh;
    logic [2:0]  ef, fl_issue;
    logic        ee;
    logic [34:0] r;
    logic [1:0]  d1;
    a  = m_regs[sa];
    b  = m_regs[sb];
    d1 = dst + 2'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_dst = dst;
    bus.cmd_srca = sa; bus.cmd_srcb = sb; bus.cmd_imm = imm;
    check("ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("issue_a", {16'd0, bus.alu_a}, {16'd0, a});
    check("issue_b", {16'd0, bus.alu_b}, {16'd0, b});
    check("issue_op", {28'd0, bus.alu_op}, {28'd0, op});
    check("issue_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("issue_ready", {31'd0, bus.cmd_ready}, 32'd0);
    fl_issue = bus.alu_flags;
    r  = alu_fn(op, a, b);
    ee = 1'b0;
    if (op == 4'd0) begin
      ed = imm; eh = 16'd0; ef = 3'd0;
      m_regs[dst] = imm; m_stat = 3'd0;
    end else if (op <= 4'd9) begin
      ed = r[15:0]; eh = r[31:16]; ef = r[34:32];
      m_stat = ef;
      if (op != 4'd9) m_regs[dst] = ed;
      if (op == 4'd3 || op == 4'd4) m_regs[d1] = eh;
    end else begin
      ee = 1'b1; ed = 16'd0; eh = 16'd0; ef = m_stat;
    end
    @(negedge clk);
    check("done_rspv", {31'd0, bus.rsp_valid}, 32'd1);
    check("done_data", {16'd0, bus.rsp_data}, {16'd0, ed});
    check("done_hi", {16'd0, bus.rsp_hi}, {16'd0, eh});
    check("done_flags", {29'd0, bus.rsp_flags}, {29'd0, ef});
    check("done_err", {31'd0, bus.rsp_err}, {31'd0, ee});
    if (op >= 4'd1 && op <= 4'd9)
      check("done_flags_vs_issue", {29'd0, bus.rsp_flags}, {29'd0, fl_issue});
    check("done_aluop0", {28'd0, bus.alu_op}, 32'd0);
    check_regs("wb");
    @(negedge clk);
    check("idle_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("idle_hold", {16'd0, bus.rsp_data}, {16'd0, ed});
    check("idle_a0", {16'd0, bus.alu_a}, 32'd0);
    check("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    int acc, pulses, last_acc;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_dst = 2'd0;
    bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd0; bus.cmd_imm = 16'd0; bus.rd_addr = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_data", {16'd0, bus.rsp_data}, 32'd0);
    check("rst_flags", {29'd0, bus.rsp_flags}, 32'd0);
    check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_regs("rst");

    // Load / add
    run_cmd(4'd0, 2'd0, 2'd0, 2'd0, 16'd3);
    run_cmd(4'd0, 2'd1, 2'd0, 2'd0, 16'd511);
    run_cmd(4'd1, 2'd2, 2'd0, 2'd1, 16'd0);
    check("add_R2", {16'd0, m_regs[2]}, 32'd514);
    // cmp leaves registers alone
    run_cmd(4'd9, 2'd3, 2'd0, 2'd1, 16'd0);
    // illegal then add
    run_cmd(4'd12, 2'd1, 2'd0, 2'd1, 16'hffff);
    run_cmd(4'd1, 2'd3, 2'd0, 2'd1, 16'd0);
    // mul with wrap-around of the high half into R0
    run_cmd(4'd0, 2'd0, 2'd0, 2'd0, 16'h0100);
    run_cmd(4'd0, 2'd1, 2'd0, 2'd0, 16'h0100);
    run_cmd(4'd3, 2'd3, 2'd0, 2'd1, 16'd0);
    check("mul_R3", {16'd0, m_regs[3]}, 32'h0000);
    check("mul_R0", {16'd0, m_regs[0]}, 32'h0001);

    // Backpressure: one command held valid for six edges
    acc = 0; pulses = 0; last_acc = -10;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_dst = 2'd3; bus.cmd_imm = 16'hbeef;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid) pulses++;
      if (bus.cmd_ready) begin
        if (acc > 0) check("bp_spacing", 32'(c - last_acc), 32'd3);
        acc++; last_acc = c;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    m_regs[3] = 16'hbeef; m_stat = 3'd0;
    check("bp_accepts", 32'(acc), 32'd2);
    check("bp_pulses", 32'(pulses), 32'd2);
    check("bp_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_regs("bp");

    // Random commands
    for (int k = 0; k < 40; k++)
      run_cmd(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));

    // Reset during ISSUE of an add to R2
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd1; bus.cmd_dst = 2'd2;
    bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rsti_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("rsti_data", {16'd0, bus.rsp_data}, 32'd0);
    check("rsti_hi", {16'd0, bus.rsp_hi}, 32'd0);
    check("rsti_flags", {29'd0, bus.rsp_flags}, 32'd0);
    check("rsti_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rsti_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_regs("rsti");
    @(negedge clk);
    check("rsti_nopulse", {31'd0, bus.rsp_valid}, 32'd0);
    check("rsti_R2", {16'd0, m_regs[2]}, 32'd0);
    run_cmd(4'd0, 2'd2, 2'd0, 2'd0, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 cmd_valid  input  1  a command is present.
REQ-005 cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 cmd_op  input  4  0 = load immediate; 1..9 = ALU op code (1 add, 2 sub, 3 mul, 4 div, 5 or, 6 and, 7 not, 8 xor, 9 cmp); 10..15 = illegal.
REQ-007 cmd_dst, cmd_srca, cmd_srcb  input  2 each  register indices R0..R3.
REQ-008 cmd_imm  input  16  immediate data for op 0.
REQ-009 alu_a, alu_b  output  16 each  ALU operands; alu_op  output  4  ALU op code.
REQ-010 alu_out, alu_hi  input  16 each; alu_flags  input  3  combinational ALU results.
REQ-011 rsp_valid  output  1  one-cycle completion pulse; rsp_data, rsp_hi  output  16 each; rsp_flags  output  3; rsp_err  output  1.
REQ-012 rd_addr  input  2; rd_data  output  16  combinational debug read of the register file.

Function
REQ-013 Register file: 4 x 16-bit registers R0..R3, plus a 3-bit status register driven on rsp_flags.
REQ-014 FSM states: IDLE, ISSUE, DONE. Transitions: IDLE->ISSUE on cmd_valid&cmd_ready; ISSUE->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 cmd_ready SHALL be 1 only in IDLE. A command held valid while the block is busy SHALL NOT be accepted until IDLE.
REQ-016 On accept, the block SHALL latch op, dst, imm, R[srca] and R[srcb]. The operand values are those present at the accept edge.
REQ-017 In ISSUE: alu_a/alu_b SHALL equal the latched operands, and alu_op SHALL equal the latched op. In every other state, alu_a, alu_b and alu_op SHALL be 0.
REQ-018 At the ISSUE->DONE edge the block SHALL capture alu_out, alu_hi and alu_flags into rsp_data, rsp_hi and rsp_flags, and SHALL perform writeback.
REQ-019 Writeback rules:
- Ops 1,2,5,6,7,8: R[dst] <= alu_out.
- Ops 3,4: R[dst] <= alu_out and R[(dst+1) mod 4] <= alu_hi; index wrap-around, so dst=3 writes R0.
- Op 9: no register write; flags only.
- Op 0: R[dst] <= imm, rsp_data = imm, rsp_hi = 0, rsp_flags = 0; ALU outputs are ignored.
REQ-020 Illegal op (10..15): no register or flag update, rsp_err = 1, rsp_data = rsp_hi = 0. rsp_err SHALL be 0 for every legal op.
REQ-021 rsp_valid SHALL be 1 exactly during DONE, i.e. the 2nd cycle after the accept edge. Throughput is one command per 3 cycles.
REQ-022 rsp_data, rsp_hi, rsp_flags and rsp_err SHALL hold their values until the next DONE.
REQ-023 rd_data SHALL reflect writebacks from the cycle after the writeback edge.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL set:
- state = IDLE;
- R0..R3 = 0 and status = 0;
- rsp_valid = 0, rsp_data = 0, rsp_hi = 0, rsp_flags = 0, rsp_err = 0.
REQ-025 Reset during ISSUE or DONE SHALL abort the command: no writeback and no rsp_valid pulse. After reset, cmd_ready = 1 in the first cycle with rst_n=1.

Verification
REQ-026 Load op 0 R0 = 3, then op 0 R1 = 511, then add (op 1) dst R2, srca R0, srcb R1 -> rsp_valid pulse 2 cycles after accept, rsp_data = 514, R2 = 514.
REQ-027 mul (op 3) with R0 = 0x0100, R1 = 0x0100, dst = 3 -> R3 = 0x0000 and R0 = 0x0001 (wrap), rsp_hi = 1.
REQ-028 cmp (op 9) with R0 = 3, R1 = 511 -> R0..R3 unchanged; rsp_flags equals alu_flags sampled in ISSUE.
REQ-029 Illegal op 12 -> rsp_err = 1 for one DONE cycle; register file unchanged; a following add gives rsp_err = 0.
REQ-030 Backpressure case: cmd_valid held high for 6 cycles with a single command -> accepts occur only in IDLE cycles, 3 cycles apart, and rsp_valid pulses once per accept.
REQ-031 Reset case: rst_n driven low during ISSUE of an add to R2 -> no rsp_valid, R2 = 0, outputs at reset values, and cmd_ready = 1 in the cycle after rst_n returns high.
